// File: rtl/pending_instr_tracker_if.sv
// Handshake bundle between the issue/commit/fence producers and the
// pending-instruction tracker.
//   issue_*      : issue slots (valid/ready, warp id, nocount marker)
//   committed*   : commit-stage retire pulses with warp id
//   fence_*      : single-channel warp fence request and completion pulse
// master = producer side (scheduler / bench), slave = tracker.
interface pending_instr_tracker_if #(
  parameter int NUM_WARPS   = 4,
  parameter int ISSUE_WIDTH = 1
);
  localparam int NW_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  logic [ISSUE_WIDTH-1:0]      issue_valid;
  logic [ISSUE_WIDTH*NW_W-1:0] issue_wid;
  logic [ISSUE_WIDTH-1:0]      issue_nocount;
  logic [ISSUE_WIDTH-1:0]      issue_ready;
  logic [ISSUE_WIDTH-1:0]      committed;
  logic [ISSUE_WIDTH*NW_W-1:0] committed_wid;
  logic                        fence_valid;
  logic [NW_W-1:0]             fence_wid;
  logic                        fence_ready;
  logic                        fence_done;

  modport master (
    output issue_valid, issue_wid, issue_nocount, committed, committed_wid,
           fence_valid, fence_wid,
    input  issue_ready, fence_ready, fence_done
  );

  modport slave (
    input  issue_valid, issue_wid, issue_nocount, committed, committed_wid,
           fence_valid, fence_wid,
    output issue_ready, fence_ready, fence_done
  );
endinterface

// File: rtl/pending_instr_tracker.sv
// Per-warp in-flight instruction counter for the scheduler.
// Counts accepted issues up and commit retire pulses down, exposes
// per-warp busy/full status, backpressures issue near saturation and
// provides a single warp fence that waits for a warp to drain.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   bus (slave)      : issue / commit / fence handshakes
//   pending_count    : registered per-warp counts, warp w at [w*CTR_W +: CTR_W]
//   warp_busy        : count != 0
//   warp_full        : count > MAX - ISSUE_WIDTH
//   all_idle         : all counts zero and no fence in progress
//   overflow_err     : sticky, a count would have exceeded MAX
//   underflow_err    : sticky, more retires than outstanding instructions
//
// state | meaning
// IDLE  | no fence active, fence_ready=1
// WAIT  | fence accepted, issue to fenced warp blocked until it drains
// DONE  | fence_done pulse cycle, returns to IDLE
module pending_instr_tracker #(
  parameter int NUM_WARPS   = 4,
  parameter int ISSUE_WIDTH = 1,
  parameter int CTR_W       = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  pending_instr_tracker_if.slave       bus,
  output logic [NUM_WARPS*CTR_W-1:0]   pending_count,
  output logic [NUM_WARPS-1:0]         warp_busy,
  output logic [NUM_WARPS-1:0]         warp_full,
  output logic                         all_idle,
  output logic                         overflow_err,
  output logic                         underflow_err
);
  localparam int NW_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int MAX  = (1 << CTR_W) - 1;
  localparam logic [CTR_W-1:0] FULL_THR  = CTR_W'(MAX - ISSUE_WIDTH);
  localparam logic [CTR_W+1:0] CNT_MAX_X = (CTR_W+2)'(MAX);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state_q;
  logic [NW_W-1:0]   fence_wid_q;
  logic              fence_ready_q;
  logic              fence_done_q;

  logic [CTR_W-1:0]  cnt_q [NUM_WARPS];
  logic [CTR_W-1:0]  cnt_d [NUM_WARPS];
  logic              ovf_q, ovf_d, unf_q, unf_d;

  logic [CTR_W+1:0]  inc [NUM_WARPS];
  logic [CTR_W+1:0]  dec [NUM_WARPS];
  logic [CTR_W+1:0]  tot [NUM_WARPS];
  logic [NUM_WARPS-1:0]   full;
  logic [ISSUE_WIDTH-1:0] issue_ready_c;
  logic              drained;

  always_comb begin : status_c
    for (int w = 0; w < NUM_WARPS; w++) begin
      full[w] = (cnt_q[w] > FULL_THR);
      warp_busy[w] = (cnt_q[w] != '0);
      pending_count[w*CTR_W +: CTR_W] = cnt_q[w];
    end
    warp_full = full;
    all_idle  = (warp_busy == '0) && (state_q == IDLE);
    drained   = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (fence_wid_q == NW_W'(w)) drained = (cnt_q[w] == '0);
    end
  end

  // Ready depends only on registered state, never on issue_valid.
  always_comb begin : ready_c
    logic [NW_W-1:0] wid_i;
    logic            hit_full;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      wid_i    = bus.issue_wid[i*NW_W +: NW_W];
      hit_full = 1'b0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (wid_i == NW_W'(w)) hit_full = full[w];
      end
      issue_ready_c[i] = !hit_full && !((state_q != IDLE) && (wid_i == fence_wid_q));
    end
  end

  assign bus.issue_ready = issue_ready_c;
  assign bus.fence_ready = fence_ready_q;
  assign bus.fence_done  = fence_done_q;
  assign overflow_err    = ovf_q;
  assign underflow_err   = unf_q;

  // Two extra bits of headroom so cnt + inc - dec is evaluated without wrap
  // and then clamped into [0, MAX].
  always_comb begin : count_c
    ovf_d = ovf_q;
    unf_d = unf_q;
    for (int w = 0; w < NUM_WARPS; w++) begin
      inc[w] = '0;
      dec[w] = '0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        if (bus.issue_valid[i] && issue_ready_c[i] && !bus.issue_nocount[i] &&
            bus.issue_wid[i*NW_W +: NW_W] == NW_W'(w))
          inc[w] = inc[w] + 1'b1;
        if (bus.committed[i] && bus.committed_wid[i*NW_W +: NW_W] == NW_W'(w))
          dec[w] = dec[w] + 1'b1;
      end
      tot[w] = {2'b00, cnt_q[w]} + inc[w];
      if (tot[w] < dec[w]) begin
        cnt_d[w] = '0;
        unf_d    = 1'b1;
      end else if (tot[w] - dec[w] > CNT_MAX_X) begin
        cnt_d[w] = CTR_W'(MAX);
        ovf_d    = 1'b1;
      end else begin
        cnt_d[w] = CTR_W'(tot[w] - dec[w]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < NUM_WARPS; w++) cnt_q[w] <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) cnt_q[w] <= cnt_d[w];
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      fence_wid_q   <= '0;
      fence_ready_q <= 1'b1;
      fence_done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.fence_valid) begin
          state_q       <= WAIT;
          fence_wid_q   <= bus.fence_wid;
          fence_ready_q <= 1'b0;
        end
        WAIT: if (drained) begin
          state_q      <= DONE;
          fence_done_q <= 1'b1;
        end
        DONE: begin
          state_q       <= IDLE;
          fence_done_q  <= 1'b0;
          fence_ready_q <= 1'b1;
        end
        default: begin
          state_q       <= IDLE;
          fence_done_q  <= 1'b0;
          fence_ready_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pending_instr_tracker.sv
module tb_pending_instr_tracker;
  localparam int NW   = 4;
  localparam int IW   = 1;
  localparam int CW   = 4;
  localparam int MAXV = 15;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pending_instr_tracker_if #(.NUM_WARPS(NW), .ISSUE_WIDTH(IW)) bus();

  logic [NW*CW-1:0] pending_count;
  logic [NW-1:0]    warp_busy, warp_full;
  logic             all_idle, overflow_err, underflow_err;

  pending_instr_tracker #(.NUM_WARPS(NW), .ISSUE_WIDTH(IW), .CTR_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave),
    .pending_count(pending_count), .warp_busy(warp_busy), .warp_full(warp_full),
    .all_idle(all_idle), .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  int checks = 0;
  int failures = 0;
  int cyc_no = 0;

  // Reference model: plain integer counts with clamping, plus the fence
  // described as a phase: 0 = none, 1 = waiting for drain, 2 = completion cycle.
  int m_cnt [NW];
  bit m_ovf, m_unf;
  int m_phase, m_fwid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  function automatic bit m_ready(input int wid);
    return !(m_cnt[wid] > MAXV - IW) && !(m_phase != 0 && wid == m_fwid);
  endfunction

  task automatic model_reset();
    for (int w = 0; w < NW; w++) m_cnt[w] = 0;
    m_ovf = 0; m_unf = 0; m_phase = 0; m_fwid = 0;
  endtask

  task automatic compare_all();
    logic [NW*CW-1:0] ec;
    logic [NW-1:0] eb, ef;
    bit idle;
    idle = (m_phase == 0);
    for (int w = 0; w < NW; w++) begin
      ec[w*CW +: CW] = CW'(m_cnt[w]);
      eb[w] = (m_cnt[w] != 0);
      ef[w] = (m_cnt[w] > MAXV - IW);
      if (m_cnt[w] != 0) idle = 0;
    end
    chk("pending_count", 32'(pending_count), 32'(ec));
    chk("warp_busy", 32'(warp_busy), 32'(eb));
    chk("warp_full", 32'(warp_full), 32'(ef));
    chk("all_idle", 32'(all_idle), 32'(idle));
    chk("issue_ready", 32'(bus.issue_ready), 32'(m_ready(int'(bus.issue_wid))));
    chk("fence_ready", 32'(bus.fence_ready), 32'(m_phase == 0));
    chk("fence_done", 32'(bus.fence_done), 32'(m_phase == 2));
    chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
    chk("underflow_err", 32'(underflow_err), 32'(m_unf));
  endtask

  task automatic model_step();
    int acc, wi, ci, t;
    bit drained;
    wi = int'(bus.issue_wid);
    ci = int'(bus.committed_wid);
    acc = (bus.issue_valid[0] && m_ready(wi) && !bus.issue_nocount[0]) ? 1 : 0;
    drained = (m_cnt[m_fwid] == 0);
    for (int w = 0; w < NW; w++) begin
      t = m_cnt[w] + ((acc == 1 && wi == w) ? 1 : 0) - ((bus.committed[0] && ci == w) ? 1 : 0);
      if (t < 0) begin m_cnt[w] = 0; m_unf = 1; end
      else if (t > MAXV) begin m_cnt[w] = MAXV; m_ovf = 1; end
      else m_cnt[w] = t;
    end
    if (m_phase == 2) m_phase = 0;
    else if (m_phase == 1) begin if (drained) m_phase = 2; end
    else if (bus.fence_valid) begin m_phase = 1; m_fwid = int'(bus.fence_wid); end
    cyc_no++;
  endtask

  task automatic drive(input logic iv, input logic [1:0] iw, input logic nc,
                       input logic cv, input logic [1:0] cw,
                       input logic fv, input logic [1:0] fw);
    bus.issue_valid   = iv;
    bus.issue_wid     = iw;
    bus.issue_nocount = nc;
    bus.committed     = cv;
    bus.committed_wid = cw;
    bus.fence_valid   = fv;
    bus.fence_wid     = fw;
  endtask

  task automatic half();
    @(negedge clk);
    compare_all();
  endtask

  task automatic fin();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc(input logic iv, input logic [1:0] iw, input logic nc,
                     input logic cv, input logic [1:0] cw,
                     input logic fv, input logic [1:0] fw);
    drive(iv, iw, nc, cv, cw, fv, fw);
    half();
    fin();
  endtask

  typedef struct {
    logic       iv;
    logic [1:0] iw;
    logic       nc;
    logic       cv;
    logic [1:0] cw;
    int         chk_w;
    int         exp_cnt;
    logic       exp_rdy;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [1:0] iw, input logic nc,
                              input logic cv, input logic [1:0] cw,
                              input int chk_w, input int exp_cnt, input logic exp_rdy);
    vec_t v;
    v.iv = iv; v.iw = iw; v.nc = nc; v.cv = cv; v.cw = cw;
    v.chk_w = chk_w; v.exp_cnt = exp_cnt; v.exp_rdy = exp_rdy;
    return v;
  endfunction

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    vec_t vecs[$];
    int pulses, at, last;

    // Test 1: reset then idle
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_count", 32'(pending_count), 0);
    chk("rst_all_idle", 32'(all_idle), 1);
    chk("rst_issue_ready", 32'(bus.issue_ready), 1);
    chk("rst_fence_ready", 32'(bus.fence_ready), 1);
    chk("rst_fence_done", 32'(bus.fence_done), 0);
    chk("rst_errs", 32'({overflow_err, underflow_err}), 0);
    chk("rst_busy_full", 32'({warp_busy, warp_full}), 0);
    fin();

    // Tests 2 and 4 as a vector table: expectations sampled before the edge.
    for (int k = 0; k < 5; k++) vecs.push_back(mk(1, 2, 0, 0, 0, 2, k, 1));
    vecs.push_back(mk(1, 2, 0, 1, 2, 2, 5, 1));
    for (int k = 0; k < 5; k++) vecs.push_back(mk(0, 2, 0, 1, 2, 2, 5 - k, 1));
    vecs.push_back(mk(0, 2, 0, 0, 0, 2, 0, 1));
    for (int k = 0; k < 8; k++) vecs.push_back(mk(1, 1, 1, 0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 1, 1, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 1));
    foreach (vecs[k]) begin
      drive(vecs[k].iv, vecs[k].iw, vecs[k].nc, vecs[k].cv, vecs[k].cw, 0, 0);
      half();
      chk("vec_cnt", 32'(pending_count[vecs[k].chk_w*CW +: CW]), 32'(vecs[k].exp_cnt));
      chk("vec_rdy", 32'(bus.issue_ready), 32'(vecs[k].exp_rdy));
      fin();
    end
    drive(0, 2, 0, 0, 0, 0, 0);
    half();
    chk("busy2_clear", 32'(warp_busy[2]), 0);
    chk("nocount_no_err", 32'({overflow_err, underflow_err}), 0);
    fin();

    // Test 3: full backpressure on warp 0
    for (int k = 0; k < 15; k++) cyc(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    half();
    chk("full0", 32'(warp_full[0]), 1);
    chk("cnt0_max", 32'(pending_count[3:0]), 15);
    chk("ready0_low", 32'(bus.issue_ready), 0);
    fin();
    drive(0, 1, 0, 0, 0, 0, 0);
    half();
    chk("ready1_high", 32'(bus.issue_ready), 1);
    chk("cnt0_held", 32'(pending_count[3:0]), 15);
    fin();
    drive(0, 0, 0, 1, 0, 0, 0);
    half();
    chk("ready0_still_low", 32'(bus.issue_ready), 0);
    fin();
    drive(0, 0, 0, 0, 0, 0, 0);
    half();
    chk("ready0_back", 32'(bus.issue_ready), 1);
    chk("cnt0_14", 32'(pending_count[3:0]), 14);
    fin();
    for (int k = 0; k < 14; k++) cyc(0, 0, 0, 1, 0, 0, 0);

    // Test 5: fence on busy warp 3, then on idle warp 2
    cyc(1, 3, 0, 0, 0, 0, 0);
    cyc(1, 3, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 3);
    drive(1, 3, 0, 0, 0, 0, 0);
    half();
    chk("fence_ready_low", 32'(bus.fence_ready), 0);
    chk("fence_blocks_issue", 32'(bus.issue_ready), 0);
    fin();
    drive(1, 1, 0, 0, 0, 0, 0);
    half();
    chk("other_warp_ready", 32'(bus.issue_ready), 1);
    fin();
    cyc(0, 0, 0, 1, 3, 0, 0);
    drive(0, 0, 0, 1, 3, 0, 0);
    half();
    last = cyc_no;
    fin();
    pulses = 0; at = -1;
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      half();
      if (bus.fence_done === 1'b1) begin pulses++; at = cyc_no; end
      fin();
    end
    chk("fence_pulses", 32'(pulses), 1);
    chk("fence_latency", 32'(at - last), 2);
    drive(0, 0, 0, 0, 0, 1, 2);
    half();
    last = cyc_no;
    fin();
    pulses = 0; at = -1;
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      half();
      if (bus.fence_done === 1'b1) begin pulses++; at = cyc_no; end
      fin();
    end
    chk("idle_fence_pulses", 32'(pulses), 1);
    chk("idle_fence_latency", 32'(at - last), 2);
    cyc(0, 1, 0, 1, 1, 0, 0);

    // Test 6: underflow is sticky; async reset mid-WAIT
    cyc(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    half();
    chk("underflow_set", 32'(underflow_err), 1);
    chk("underflow_cnt0", 32'(pending_count[3:0]), 0);
    fin();
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("underflow_sticky", 32'(underflow_err), 1);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    #3 reset_n = 1'b0;
    #1;
    chk("async_cnt", 32'(pending_count), 0);
    chk("async_fence_ready", 32'(bus.fence_ready), 1);
    chk("async_underflow", 32'(underflow_err), 0);
    chk("async_all_idle", 32'(all_idle), 1);
    model_reset();
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_no_done", 32'(bus.fence_done), 0);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      half();
      if (bus.fence_done === 1'b1) pulses++;
      fin();
    end
    chk("abandoned_fence_no_done", 32'(pulses), 0);

    // Randomized traffic against the model
    for (int k = 0; k < 500; k++) begin
      cyc(($urandom % 4) != 0, 2'($urandom % 4), ($urandom % 5) == 0,
          ($urandom % 2) != 0, 2'($urandom % 4),
          ($urandom % 8) == 0, 2'($urandom % 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pending_instr_tracker.md
Name: pending_instr_tracker

Overview:
- Per-warp in-flight instruction counter that sits directly downstream of the commit stage, in the scheduler.
- Counts issues and retires them using the commit stage's committed/committed_wid pulses.
- Gives the scheduler per-warp busy and full status, and backpressures issue when a warp's counter is near saturation.
- Provides a single-channel warp fence (wait until a warp has drained) and sticky overflow/underflow error flags.

Parameters:
- NUM_WARPS, 4, number of warps tracked; NW_W = max(1, clog2(NUM_WARPS)).
- ISSUE_WIDTH, 1, number of parallel issue slots and commit slots.
- CTR_W, 4, counter width per warp; MAX = 2^CTR_W - 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- issue_valid  in  ISSUE_WIDTH  issue slot i presents an instruction.
- issue_wid  in  ISSUE_WIDTH*NW_W  warp id per slot.
- issue_nocount  in  ISSUE_WIDTH  1 = instruction must not be counted (non-final tensor sub-ops).
- issue_ready  out  ISSUE_WIDTH  slot i accepted when valid & ready.
- committed  in  ISSUE_WIDTH  commit-stage retire pulse per slot.
- committed_wid  in  ISSUE_WIDTH*NW_W  warp retired per slot.
- pending_count  out  NUM_WARPS*CTR_W  registered per-warp count.
- warp_busy  out  NUM_WARPS  count != 0.
- warp_full  out  NUM_WARPS  count > MAX - ISSUE_WIDTH.
- all_idle  out  1  all counts zero and fence FSM in IDLE.
- fence_valid  in  1  fence request.
- fence_wid  in  NW_W  warp to drain.
- fence_ready  out  1  fence request accepted when valid & ready.
- fence_done  out  1  one-cycle pulse: fenced warp has drained.
- overflow_err  out  1  sticky flag.
- underflow_err  out  1  sticky flag.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All counters 0; FSM to IDLE; error flags 0.
  - Resulting outputs: fence_done=0, fence_ready=1, warp_busy=0, warp_full=0, all_idle=1, issue_ready = all ones.
  - Reset asserted mid-fence abandons the fence; no fence_done is produced.
- issue_ready[i] = !warp_full[issue_wid[i]] && !(state!=IDLE && issue_wid[i]==fence_wid_r).
  - Combinational from registered state only; it never depends on issue_valid.
- Per-warp update, every cycle:
  - inc[w] = number of slots with issue_valid & issue_ready & !issue_nocount & wid==w.
  - dec[w] = number of slots with committed & committed_wid==w.
  - Slots landing on the same warp in one cycle all count.
  - Compute in CTR_W+2 bits: t = cnt + inc.
  - If t < dec: next = 0 and underflow_err <= 1.
  - Else if t - dec > MAX: next = MAX and overflow_err <= 1.
  - Else next = t - dec.
- Simultaneous issue and commit to the same warp net out in the same cycle (count 3, +1, -1 -> 3).
- Latency: an event in cycle t is reflected in pending_count, busy and full at t+1. committed is trusted as already registered upstream; no extra delay is added.
- Fence FSM:
  - IDLE: fence_ready=1. On fence_valid, latch fence_wid into fence_wid_r and go to WAIT.
  - WAIT: fence_ready=0 and issue to fence_wid_r is blocked. When cnt[fence_wid_r]==0 (registered value), go to DONE.
  - DONE: fence_done=1 for exactly this cycle, then IDLE.
  - A fence on an already idle warp therefore takes: accept, WAIT one cycle, DONE = fence_done two cycles after acceptance.
  - Commits continue during WAIT; issues to other warps continue.
- Error flags clear only on reset. Saturation and clamping keep the counters bounded; no wrap-around ever occurs.
- fence_wid >= NUM_WARPS: behaviour undefined; the bench does not drive it.

Test Plan:
1. Reset then idle: hold reset_n=0 for 3 cycles, release -> pending_count all 0, all_idle=1, issue_ready=1, fence_ready=1, errors 0.
2. Issue/commit on wid=2:
   - Issue 5 to wid 2 -> count[2]=5 one cycle after the last issue.
   - Then, in one cycle, issue 1 and commit 1 on wid 2 -> count stays 5.
   - Then 5 commits -> count[2]=0 and warp_busy[2]=0.
3. Full backpressure (CTR_W=4, ISSUE_WIDTH=1): issue 15 to wid 0 -> warp_full[0]=1 and issue_ready=0 for wid 0 while wid 1 stays ready; one commit on wid 0 -> ready the next cycle.
4. nocount: issue 8 with nocount=1 plus 1 with nocount=0 to wid 1, then commit 1 -> count[1] 0 -> 1 -> 0, no errors.
5. Fence:
   - Count[3]=2; fence on wid 3 -> fence_ready=0 and issue_ready low for wid 3.
   - Commit 2 -> fence_done pulses exactly once, 2 cycles after the last commit; then IDLE.
   - A fence on an idle warp -> fence_done 2 cycles after acceptance.
6. Errors and async reset:
   - Commit on wid 0 with count 0 -> count stays 0, underflow_err=1 and sticky.
   - Assert reset_n low mid-WAIT -> all state cleared immediately without waiting for a clock edge; no fence_done is produced.
